// File: rtl/counter_cmd_gen_pkg.sv
// counter_cmd_pkg: shared FSM state encoding and direction codes for counter_cmd_gen
package counter_cmd_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_e;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/counter_cmd_gen_if.sv
// counter_cmd_gen_if: button inputs and counter controls (E pulse, D direction, busy)
//   master drives btn_up/btn_dn and observes E/D/busy; slave is the command generator
interface counter_cmd_gen_if;
    logic btn_up;
    logic btn_dn;
    logic E;
    logic D;
    logic busy;
    modport master (output btn_up, btn_dn, input E, D, busy);
    modport slave (input btn_up, btn_dn, output E, D, busy);
endinterface

// File: rtl/counter_cmd_gen_btn_debounce.sv
// btn_debounce: 2-FF sync, debounce and registered rise detect for one raw button
//   clk, rst (sync, active-low), raw (async button) -> db (debounced level), rise (1-cycle pulse on db 0->1)
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic s1_q, s2_q, db_q, rise_q;
    logic [CW-1:0] cnt_q;
    logic accept;
    // the synced level has now differed from db for DEB_CYCLES consecutive clocks
    assign accept = (s2_q != db_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            db_q   <= 1'b0;
            rise_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            cnt_q  <= (s2_q == db_q || accept) ? '0 : cnt_q + 1'b1;
            db_q   <= accept ? s2_q : db_q;
            rise_q <= accept & s2_q;
        end
    end
    assign db   = db_q;
    assign rise = rise_q;
endmodule

// File: rtl/counter_cmd_gen.sv
// counter_cmd_gen: turns up/down buttons into counter E pulses and D direction with hold auto-repeat
//   clk, rst (sync, active-low); bus.slave: btn_up, btn_dn in; E, D, busy out
module counter_cmd_gen
    import counter_cmd_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int HOLD_CYCLES   = 5000,
    parameter int REPEAT_CYCLES = 1000
) (
    input logic               clk,
    input logic               rst,
    counter_cmd_gen_if.slave  bus
);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          e_q, d_q;
    logic          up_db, dn_db, up_rise, dn_rise;
    logic          held, other, tick;
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
        .clk(clk), .rst(rst), .raw(bus.btn_up), .db(up_db), .rise(up_rise)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
        .clk(clk), .rst(rst), .raw(bus.btn_dn), .db(dn_db), .rise(dn_rise)
    );
    // D doubles as the latched button: it only changes on a pulse leaving IDLE
    assign held  = (d_q == DIR_DN) ? dn_db : up_db;
    assign other = (d_q == DIR_DN) ? up_db : dn_db;
    assign tick  = timer_q == TW'(((state_q == HOLD) ? HOLD_CYCLES : REPEAT_CYCLES) - 1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            e_q     <= 1'b0;
            d_q     <= DIR_UP;
        end else begin
            e_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (up_db && dn_db) begin
                        state_q <= LOCK;
                    end else if (up_rise ^ dn_rise) begin
                        e_q     <= 1'b1;
                        d_q     <= dn_rise ? DIR_DN : DIR_UP;
                        state_q <= HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (other) begin
                        state_q <= LOCK;
                    end else if (!held) begin
                        state_q <= IDLE;
                    end else if (tick) begin
                        e_q     <= 1'b1;
                        state_q <= REPEAT;
                        timer_q <= '0;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                LOCK: if (!up_db && !dn_db) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.E    = e_q;
    assign bus.D    = d_q;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_counter_cmd_gen.sv
// tb_counter_cmd_gen: scoreboard bench for counter_cmd_gen with a behavioural button model
module tb_counter_cmd_gen;
    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 8;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_LOCK = 2;

    typedef struct {int cyc; logic d;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    counter_cmd_gen_if bus();

    counter_cmd_gen #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int ncmp = 0, nfail = 0, cyc = 0;
    logic done = 1'b0, fin = 1'b0;
    logic [7:0] cnt_dut = 8'd0, cnt_exp = 8'd0;

    // reference model: button -> 2-sample delay -> window of DEB samples -> press/auto-repeat rules
    int m_state = M_IDLE, since = 0;
    logic first = 1'b1, pulse, sync, m_d = 1'b0, m_busy = 1'b0;
    logic [1:0] raw, r1, r2, db, rise;
    logic [DEB-1:0] win [2];

    always @(posedge clk) begin
        cyc++;
        raw = {bus.btn_dn, bus.btn_up};
        if (!rst) begin
            m_state = M_IDLE; since = 0; first = 1'b1; m_d = 1'b0;
            r1 = '0; r2 = '0; db = '0; rise = '0;
            for (int i = 0; i < 2; i++) win[i] = '0;
        end else begin
            pulse = 1'b0;
            if (m_state == M_IDLE) begin
                if (db[0] && db[1]) m_state = M_LOCK;
                else if (rise[0] != rise[1]) begin
                    pulse = 1'b1; m_d = rise[1]; m_state = M_ACTIVE; since = 0; first = 1'b1;
                end
            end else if (m_state == M_ACTIVE) begin
                if (db[m_d ? 0 : 1]) m_state = M_LOCK;
                else if (!db[m_d]) m_state = M_IDLE;
                else begin
                    since++;
                    if (since == (first ? HOLD : RPT)) begin
                        pulse = 1'b1; since = 0; first = 1'b0;
                    end
                end
            end else if (!db[0] && !db[1]) m_state = M_IDLE;
            for (int i = 0; i < 2; i++) begin
                sync = r2[i]; r2[i] = r1[i]; r1[i] = raw[i];
                win[i] = {win[i][DEB-2:0], sync};
                rise[i] = 1'b0;
                if (win[i] == {DEB{~db[i]}}) begin
                    db[i] = sync; rise[i] = sync;
                end
            end
            if (pulse) begin
                q.push_back('{cyc, m_d});
                cnt_exp = m_d ? cnt_exp - 8'd1 : cnt_exp + 8'd1;
            end
        end
        m_busy = (m_state != M_IDLE);
    end

    // monitor: pops the scoreboard whenever the DUT pulses E, and tracks D/busy every cycle
    exp_t x;
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            x = q.pop_front();
            ncmp++; nfail++;
            $display("FAIL pulse_missing: no E seen, required E at cycle %0d D=%0b", x.cyc, x.d);
        end
        if (bus.E === 1'b1) begin
            cnt_dut = bus.D ? cnt_dut - 8'd1 : cnt_dut + 8'd1;
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL pulse_extra: E at cycle %0d D=%0b, required no E", cyc, bus.D);
            end else begin
                x = q.pop_front();
                if (x.cyc != cyc || x.d !== bus.D) begin
                    nfail++;
                    $display("FAIL pulse: E at cycle %0d D=%0b, required cycle %0d D=%0b", cyc, bus.D, x.cyc, x.d);
                end
            end
        end
        ncmp++;
        if (bus.busy !== m_busy) begin
            nfail++;
            $display("FAIL busy: cycle %0d got %0b, required %0b", cyc, bus.busy, m_busy);
        end
        ncmp++;
        if (bus.D !== m_d) begin
            nfail++;
            $display("FAIL dir: cycle %0d got %0b, required %0b", cyc, bus.D, m_d);
        end
        if (done && !fin) begin
            fin = 1'b1;
            ncmp++;
            if (q.size() != 0) begin
                nfail++;
                $display("FAIL drain: %0d pulses outstanding, required 0", q.size());
            end
            ncmp++;
            if (cnt_dut !== cnt_exp) begin
                nfail++;
                $display("FAIL count: counter got %0d, required %0d", cnt_dut, cnt_exp);
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input logic dn, input int len);
        if (dn) bus.btn_dn = 1'b1; else bus.btn_up = 1'b1;
        clks(len);
        bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
        clks(30);
    endtask

    initial begin
        bus.btn_up = 1'b1; bus.btn_dn = 1'b0;
        clks(2);
        rst = 1'b1;
        clks(15);
        bus.btn_up = 1'b0;
        clks(30);
        tap(1'b0, 10);
        for (int i = 0; i < 6; i++) begin
            bus.btn_dn = ~bus.btn_dn;
            clks(2);
        end
        bus.btn_dn = 1'b1;
        clks(15);
        bus.btn_dn = 1'b0;
        clks(30);
        tap(1'b0, 62);
        bus.btn_up = 1'b1;
        clks(40);
        bus.btn_dn = 1'b1;
        clks(15);
        bus.btn_dn = 1'b0;
        clks(20);
        bus.btn_up = 1'b0;
        clks(20);
        tap(1'b0, 10);
        bus.btn_up = 1'b1;
        clks(40);
        rst = 1'b0;
        clks(1);
        rst = 1'b1;
        clks(40);
        bus.btn_up = 1'b0;
        clks(30);
        for (int i = 0; i < 250; i++) begin
            bus.btn_up = 1'($urandom_range(0, 1));
            bus.btn_dn = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 40) == 0) rst = 1'b0;
            clks(1);
            rst = 1'b1;
            clks(($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 8));
        end
        bus.btn_up = 1'b0; bus.btn_dn = 1'b0;
        clks(40);
        done = 1'b1;
        clks(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
